// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: turns op/field requests into 32-bit machine words,
// buffers them in a FIFO and streams them out with an auto-incrementing byte address.
// Optional immediate range check enabled by defining LEGV8_ENC_IMM_CHECK_EN.
module legv8_instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rn,
  input  logic [4:0]               req_rm,
  input  logic [25:0]              req_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     imm_ovf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       enc;
  logic              imm_bad, push, wr_en, pop;

  always_comb begin
    enc = '0;
    case (req_op)
      3'd0: enc = {11'b10001011000, req_rm, 6'b0, req_rn, req_rd};
      3'd1: enc = {11'b11001011000, req_rm, 6'b0, req_rn, req_rd};
      3'd2: enc = {11'b10001010000, req_rm, 6'b0, req_rn, req_rd};
      3'd3: enc = {11'b10101010000, req_rm, 6'b0, req_rn, req_rd};
      3'd4: enc = {11'b11111000010, req_imm[8:0], 2'b00, req_rn, req_rd};
      3'd5: enc = {11'b11111000000, req_imm[8:0], 2'b00, req_rn, req_rd};
      3'd6: enc = {8'b10110100, req_imm[18:0], req_rd};
      3'd7: enc = {6'b000101, req_imm};
      default: enc = '0;
    endcase
  end

`ifdef LEGV8_ENC_IMM_CHECK_EN
  always_comb begin
    imm_bad = 1'b0;
    if ((req_op == 3'd4 || req_op == 3'd5) && (|req_imm[25:9])) imm_bad = 1'b1;
    if (req_op == 3'd6 && (|req_imm[25:19]))                    imm_bad = 1'b1;
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign push      = req_valid && ready_q;
  assign wr_en     = push && !imm_bad;
  assign pop       = out_valid && out_ready;
  assign req_ready = ready_q;
  assign out_valid = (count_q != '0);
  // Force zero when empty so stale storage never shows on the bus.
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= enc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      addr_q   <= ADDR_W'(BASE_ADDR);
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= addr_q + ADDR_W'(4);
      end
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(DEPTH));
    end
  end

`ifdef LEGV8_ENC_IMM_CHECK_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= push && imm_bad;
  end
  assign imm_ovf = ovf_q;
`else
  assign imm_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed bench for legv8_instr_encoder; a second ADDR_W=4 instance checks address wrap.
module tb_legv8_instr_encoder;
  logic        clk = 1'b0;
  logic        reset, req_valid, out_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd, req_rn, req_rm;
  logic [25:0] req_imm;

  logic        req_ready, out_valid, imm_ovf;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic [2:0]  fifo_count;

  logic        req_ready4, out_valid4, imm_ovf4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;
  logic [2:0]  fifo_count4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  legv8_instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .fifo_count(fifo_count), .imm_ovf(imm_ovf));

  legv8_instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
    .out_addr(out_addr4), .fifo_count(fifo_count4), .imm_ovf(imm_ovf4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fields(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [25:0] imm);
    req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [25:0] imm);
    fields(op, rd, rn, rm, imm);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
    fields(3'd0, 5'd0, 5'd0, 5'd0, 26'd0);
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready",  {31'b0, req_ready}, 32'd1);
    chk("rst_valid",  {31'b0, out_valid}, 32'd0);
    chk("rst_instr",  out_instr, 32'h0);
    chk("rst_addr",   {24'b0, out_addr}, 32'h0);
    chk("rst_count",  {29'b0, fifo_count}, 32'd0);
    chk("rst_ovf",    {31'b0, imm_ovf}, 32'd0);

    // Encodings, one word in flight at a time
    send(3'd0, 5'd3, 5'd1, 5'd2, 26'd0);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_instr", out_instr, 32'h8B020023);
    chk("add_addr",  {24'b0, out_addr}, 32'h00);
    send(3'd1, 5'd3, 5'd1, 5'd2, 26'd0);
    chk("sub_instr", out_instr, 32'hCB020023);
    chk("sub_addr",  {24'b0, out_addr}, 32'h04);
    send(3'd4, 5'd5, 5'd2, 5'd0, 26'd8);
    chk("ldur_instr", out_instr, 32'hF8408045);
    chk("ldur_addr",  {24'b0, out_addr}, 32'h08);
    send(3'd5, 5'd5, 5'd2, 5'd0, 26'd8);
    chk("stur_instr", out_instr, 32'hF8008045);
    send(3'd6, 5'd1, 5'd0, 5'd0, 26'd4);
    chk("cbz_instr", out_instr, 32'hB4000081);
    send(3'd7, 5'd0, 5'd0, 5'd0, 26'd3);
    chk("b_instr", out_instr, 32'h14000003);
    chk("b_addr",  {24'b0, out_addr}, 32'h14);
    send(3'd2, 5'd4, 5'd6, 5'd7, 26'h3FFFFFF);
    chk("and_instr", out_instr, 32'h8A0700C4);
    send(3'd3, 5'd31, 5'd31, 5'd31, 26'd0);
    chk("orr_instr", out_instr, 32'hAA1F03FF);
    tick();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_instr", out_instr, 32'h0);

    // Backpressure: fill, block the fifth, then drain in order
    do_reset();
    out_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fields(3'd0, 5'(i), 5'd1, 5'd2, 26'd0);
      tick();
    end
    fields(3'd0, 5'd4, 5'd1, 5'd2, 26'd0);
    chk("full_count", {29'b0, fifo_count}, 32'd4);
    chk("full_ready", {31'b0, req_ready}, 32'd0);
    chk("full_head",  out_instr, 32'h8B020020);
    tick();
    chk("blk_count", {29'b0, fifo_count}, 32'd4);
    chk("blk_head",  out_instr, 32'h8B020020);
    chk("blk_addr",  {24'b0, out_addr}, 32'h00);
    out_ready = 1'b1;
    tick();
    chk("drn1_instr", out_instr, 32'h8B020021);
    chk("drn1_addr",  {24'b0, out_addr}, 32'h04);
    chk("drn1_count", {29'b0, fifo_count}, 32'd3);
    chk("drn1_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("drn2_instr", out_instr, 32'h8B020022);
    chk("drn2_addr",  {24'b0, out_addr}, 32'h08);
    chk("drn2_count", {29'b0, fifo_count}, 32'd3);
    tick();
    chk("drn3_instr", out_instr, 32'h8B020023);
    chk("drn3_addr",  {24'b0, out_addr}, 32'h0C);
    tick();
    chk("drn4_instr", out_instr, 32'h8B020024);
    chk("drn4_addr",  {24'b0, out_addr}, 32'h10);
    tick();
    chk("drn_empty", {31'b0, out_valid}, 32'd0);

    // Out-of-range D-type immediate
    send(3'd4, 5'd5, 5'd2, 5'd0, 26'h200);
`ifdef LEGV8_ENC_IMM_CHECK_EN
    chk("ovf_pulse", {31'b0, imm_ovf}, 32'd1);
    chk("ovf_count", {29'b0, fifo_count}, 32'd0);
    chk("ovf_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("ovf_clear", {31'b0, imm_ovf}, 32'd0);
`else
    chk("trunc_instr", out_instr, 32'hF8400045);
    chk("trunc_ovf",   {31'b0, imm_ovf}, 32'd0);
    tick();
`endif

    // Reset mid-operation discards buffered words
    do_reset();
    out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd1, 5'd2, 26'd0);
    send(3'd0, 5'd2, 5'd1, 5'd2, 26'd0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 26'd0);
    chk("buf_count", {29'b0, fifo_count}, 32'd3);
    do_reset();
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_count", {29'b0, fifo_count}, 32'd0);
    chk("mrst_addr",  {24'b0, out_addr}, 32'h00);
    chk("mrst_ready", {31'b0, req_ready}, 32'd1);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      send(3'd0, 5'd3, 5'd1, 5'd2, 26'd0);
      chk("post_instr", out_instr, 32'h8B020023);
      chk("post_addr",  {24'b0, out_addr}, 32'(4 * j));
      chk("wrap_addr",  {28'b0, out_addr4}, 32'((4 * j) % 16));
    end
    tick();
    chk("end_valid", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
